// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants, types and next-state function for the 8-bit PRBS link.
// The same lfsr_next() is used by the generator, LFSR_checker and bench models so all
// sides agree on the Galois polynomial and the zero-state insertion.
package lfsr_pkg;

    localparam int                LFSR_W          = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAP_MASK   = 8'h8D;
    localparam logic [LFSR_W-1:0] LFSR_RESET_SEED = 8'h01;

    typedef logic [LFSR_W-1:0] lfsr_word_t;

    // Action taken by the generator on a clock edge (reset is handled separately).
    typedef enum logic [1:0] {
        LFSR_OP_IDLE,
        LFSR_OP_STEP,
        LFSR_OP_LOAD
    } lfsr_op_e;

    // One Galois step with an arbitrary tap mask. Feedback is the MSB, flipped when the
    // low bits are all zero: this splices 8'h00 into the cycle between 8'h80 and the
    // normal successor of 8'h80, so the all-zero word is a regular member of the stream.
    // Bit 0 of the mask is implied by the feedback landing in bit 0.
    function automatic lfsr_word_t lfsr_next_mask(input lfsr_word_t s, input lfsr_word_t mask);
        logic       fb;
        lfsr_word_t n;
        fb = s[LFSR_W-1] ^ (s[LFSR_W-2:0] == '0);
        n  = {s[LFSR_W-2:0], fb};
        if (fb) begin
            n = n ^ {mask[LFSR_W-1:1], 1'b0};
        end
        return n;
    endfunction

    // Step with the team polynomial.
    function automatic lfsr_word_t lfsr_next(input lfsr_word_t s);
        return lfsr_next_mask(s, LFSR_TAP_MASK);
    endfunction

endpackage

// File: rtl/lfsr_err_injector.sv
// lfsr_err_injector: counts emitted words and flips bit 0 of every Nth one so the
// downstream checker can be pushed out of lock and observed relocking.
// Only instantiated when LFSR_ERR_INJECT_EN is defined.
module lfsr_err_injector
    import lfsr_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       advance_i,
    input  logic       err_en_i,
    input  logic [7:0] err_period_i,
    input  lfsr_word_t word_i,
    output lfsr_word_t word_o,
    output logic       err_inj_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic [7:0] countInc;
    logic       errInj_q;
    logic       errInj_d;
    logic       injectHit;

    // The counter counts every emitted word; a match against a non-zero period while
    // enabled corrupts that word. A period lowered below the current count simply
    // lets the counter run on through 255 before it can match again.
    always_comb begin
        countInc  = count_q + 8'd1;
        injectHit = advance_i && err_en_i && (err_period_i != 8'd0) && (countInc == err_period_i);
        word_o    = word_i ^ {{(LFSR_W-1){1'b0}}, injectHit};
        count_d   = count_q;
        errInj_d  = 1'b0;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (advance_i) begin
            count_d  = injectHit ? 8'd0 : countInc;
            errInj_d = injectHit;
        end
    end

    // Register the counter and the flag that travels with the corrupted word.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 8'd0;
            errInj_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            errInj_q <= errInj_d;
        end
    end

    assign err_inj_o = errInj_q;

endmodule

// File: rtl/lfsr_generator.sv
// lfsr_generator: PRBS word source for the 8-bit link. Advances one Galois step per
// valid cycle, reloads a seed on soft reset and flags when the loaded seed comes back.
// Define LFSR_ERR_INJECT_EN to build the bit-0 error injector; without it the error
// ports are accepted but ignored and o_err_inj stays low.
module lfsr_generator
    import lfsr_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RESET_SEED = LFSR_RESET_SEED,
    parameter logic [LFSR_W-1:0] TAP_MASK   = LFSR_TAP_MASK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_valid,
    input  logic              i_soft_reset,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_err_en,
    input  logic [7:0]        i_err_period,
    output logic [LFSR_W-1:0] o_LFSR,
    output logic              o_valid,
    output logic              o_wrap,
    output logic              o_err_inj
);

    lfsr_op_e   op;
    lfsr_word_t nextState;
    lfsr_word_t outWord;
    lfsr_word_t state_q;
    lfsr_word_t state_d;
    lfsr_word_t seed_q;
    lfsr_word_t seed_d;
    lfsr_word_t word_q;
    lfsr_word_t word_d;
    logic       valid_q;
    logic       valid_d;
    logic       wrap_q;
    logic       wrap_d;

    // Decide what this edge does; a seed load wins over an advance request.
    always_comb begin
        op = LFSR_OP_IDLE;
        if (i_soft_reset) begin
            op = LFSR_OP_LOAD;
        end else if (i_valid) begin
            op = LFSR_OP_STEP;
        end
    end

    assign nextState = lfsr_next_mask(state_q, TAP_MASK);

`ifdef LFSR_ERR_INJECT_EN
    logic advance;
    logic load;

    assign advance = (op == LFSR_OP_STEP);
    assign load    = (op == LFSR_OP_LOAD);

    lfsr_err_injector u_err_injector (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (load),
        .advance_i    (advance),
        .err_en_i     (i_err_en),
        .err_period_i (i_err_period),
        .word_i       (nextState),
        .word_o       (outWord),
        .err_inj_o    (o_err_inj)
    );
`else
    logic unused_err_inputs;

    assign unused_err_inputs = ^{i_err_en, i_err_period};
    assign outWord           = nextState;
    assign o_err_inj         = 1'b0;
`endif

    // Next-state for the sequence state, the remembered seed and the output word.
    // Only the emitted word may carry an injected error; the state always takes the
    // clean successor so the stream resumes uncorrupted.
    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        word_d  = word_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        case (op)
            LFSR_OP_LOAD: begin
                state_d = i_seed;
                seed_d  = i_seed;
            end
            LFSR_OP_STEP: begin
                state_d = nextState;
                word_d  = outWord;
                valid_d = 1'b1;
                wrap_d  = (nextState == seed_q);
            end
            default: begin
            end
        endcase
    end

    // State and output registers; reset restores the power-on seed and clears outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_SEED;
            seed_q  <= RESET_SEED;
            word_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_LFSR  = word_q;
    assign o_valid = valid_q;
    assign o_wrap  = wrap_q;

endmodule
